// File: rtl/bram_ctrl_pkg.sv
// Shared types for the word-to-beat BRAM initiator: FSM states and beat index sizing.
package bram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_LAST,
        RESP
    } state_t;

    localparam int BEATS_DEFAULT = 4;

    // A single-beat word still needs a one-bit counter.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BEAT_IDX_W = idx_width(BEATS_DEFAULT);

    typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

endpackage

// File: rtl/bram_word_ctrl_if.sv
// Core-side word request/response channel: valid/ready request in, valid/ready response out.
interface bram_word_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int BEATS      = 4
);
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_write;
    logic [ADDR_WIDTH-1:0]         req_addr;
    logic [BEATS*DATA_WIDTH-1:0]   req_wdata;
    logic [BEATS-1:0]              req_mask;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [BEATS*DATA_WIDTH-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_mask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_mask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/bram.sv
// True dual-port byte RAM, one registered read per port (data valid the cycle after the address edge).
module bram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_write_a,
    input  logic [ADDR_WIDTH-1:0] i_addr_a,
    input  logic [DATA_WIDTH-1:0] i_data_a,
    output logic [DATA_WIDTH-1:0] o_data_a,
    input  logic                  i_write_b,
    input  logic [ADDR_WIDTH-1:0] i_addr_b,
    input  logic [DATA_WIDTH-1:0] i_data_b,
    output logic [DATA_WIDTH-1:0] o_data_b
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Both ports share one process; on a same-address double write port B lands last.
    always_ff @(posedge i_clk) begin
        o_data_a <= mem[i_addr_a];
        o_data_b <= mem[i_addr_b];
        if (i_write_a) mem[i_addr_a] <= i_data_a;
        if (i_write_b) mem[i_addr_b] <= i_data_b;
    end
endmodule

// File: rtl/bram_word_ctrl.sv
// Splits core word load/stores into BEATS single-beat BRAM accesses; store ack BEATS edges, load data BEATS+1 edges after accept.
// Holds RESP while rsp_ready is low; accepts a new request only from IDLE.
module bram_word_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int BEATS      = BEATS_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    bram_word_ctrl_if.slave       core,
    output logic                  o_mem_write,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    input  logic [DATA_WIDTH-1:0] i_mem_data
);
    localparam int WORD_W = BEATS * DATA_WIDTH;
    localparam int CNT_W  = idx_width(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t                state;
    logic [CNT_W-1:0]      beat;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_W-1:0]     wdata_q;
    logic [BEATS-1:0]      mask_q;
    logic [WORD_W-1:0]     rdata_q;
    logic                  rsp_valid_q;

    logic [CNT_W-1:0]      beat_nxt;
    logic [CNT_W-1:0]      beat_prv;
    logic [ADDR_WIDTH-1:0] addr_nxt;

    assign beat_nxt = beat + CNT_W'(1);
    assign beat_prv = beat - CNT_W'(1);
    assign addr_nxt = addr_q + ADDR_WIDTH'(beat_nxt);

    assign core.req_ready = (state == IDLE);
    assign core.rsp_valid = rsp_valid_q;
    assign core.rsp_rdata = rdata_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            beat        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            o_mem_write <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_mem_write <= 1'b0;
                    if (core.req_valid) begin
                        addr_q     <= core.req_addr;
                        wdata_q    <= core.req_wdata;
                        mask_q     <= core.req_mask;
                        rdata_q    <= '0;
                        beat       <= '0;
                        o_mem_addr <= core.req_addr;
                        // Beat 0 is presented straight from the request so the bus starts the next cycle.
                        if (core.req_write) begin
                            state       <= WR;
                            o_mem_data  <= core.req_wdata[DATA_WIDTH-1:0];
                            o_mem_write <= core.req_mask[0];
                        end else begin
                            state <= RD;
                        end
                    end
                end
                WR: begin
                    if (beat == LAST_BEAT) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        o_mem_write <= 1'b0;
                    end else begin
                        beat        <= beat_nxt;
                        o_mem_addr  <= addr_nxt;
                        o_mem_data  <= wdata_q[int'(beat_nxt)*DATA_WIDTH +: DATA_WIDTH];
                        o_mem_write <= mask_q[beat_nxt];
                    end
                end
                RD: begin
                    // Data on i_mem_data belongs to the beat addressed one cycle earlier.
                    if (beat != '0)
                        rdata_q[int'(beat_prv)*DATA_WIDTH +: DATA_WIDTH] <= i_mem_data;
                    if (beat == LAST_BEAT) begin
                        state <= RD_LAST;
                    end else begin
                        beat       <= beat_nxt;
                        o_mem_addr <= addr_nxt;
                    end
                end
                RD_LAST: begin
                    rdata_q[int'(LAST_BEAT)*DATA_WIDTH +: DATA_WIDTH] <= i_mem_data;
                    state       <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (core.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_word_ctrl.sv
// Directed bench: controller on BRAM port A, port B used to pre-fill and inspect memory.
module tb_bram_word_ctrl;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int NB = 4;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    bram_word_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(NB)) core ();

    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          b_write;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic [DW-1:0] b_rdata;

    bram_word_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BEATS(NB)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .core        (core),
        .o_mem_write (mem_write),
        .o_mem_addr  (mem_addr),
        .o_mem_data  (mem_wdata),
        .i_mem_data  (mem_rdata)
    );

    bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_bram (
        .i_clk     (i_clk),
        .i_write_a (mem_write),
        .i_addr_a  (mem_addr),
        .i_data_a  (mem_wdata),
        .o_data_a  (mem_rdata),
        .i_write_b (b_write),
        .i_addr_b  (b_addr),
        .i_data_b  (b_wdata),
        .o_data_b  (b_rdata)
    );

    int errors    = 0;
    int checks    = 0;
    int rsp_count = 0;

    always @(posedge i_clk)
        if (core.rsp_valid && core.rsp_ready) rsp_count++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        b_addr  = a;
        b_wdata = d;
        b_write = 1'b1;
        tick();
        b_write = 1'b0;
    endtask

    task automatic pb_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        b_addr = a;
        tick();
        d = b_rdata;
    endtask

    // Issue one request; report edges from accept to rsp_valid and the returned data, then retire it.
    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [31:0] wd,
                          input logic [3:0] m, output logic [31:0] rd, output int lat);
        int guard = 0;
        while (!core.req_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!core.req_ready) chk("req_ready_timeout", 64'd0, 64'd1);
        core.req_valid = 1'b1;
        core.req_write = wr;
        core.req_addr  = a;
        core.req_wdata = wd;
        core.req_mask  = m;
        tick();
        core.req_valid = 1'b0;
        core.req_addr  = ~a;
        core.req_wdata = ~wd;
        core.req_mask  = ~m;
        core.req_write = ~wr;
        lat = 0;
        while (!core.rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!core.rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
        rd = core.rsp_rdata;
        core.rsp_ready = 1'b1;
        tick();
        core.rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [DW-1:0] bd;
        int lat;
        logic [AW-1:0] wrap_a [4];
        logic [DW-1:0] wrap_d [4];

        core.req_valid = 1'b0;
        core.req_write = 1'b0;
        core.req_addr  = '0;
        core.req_wdata = '0;
        core.req_mask  = '0;
        core.rsp_ready = 1'b0;
        b_write = 1'b0;
        b_addr  = '0;
        b_wdata = '0;

        #12;
        chk("rst_rsp_valid", 64'(core.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(core.rsp_rdata), 64'd0);
        chk("rst_mem_write", 64'(mem_write), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_data", 64'(mem_wdata), 64'd0);
        chk("rst_req_ready", 64'(core.req_ready), 64'd1);
        tick();
        i_rst_n = 1'b1;
        tick();

        // Full-mask store then load
        do_req(1'b1, 16'h0010, 32'hDDCCBBAA, 4'b1111, rd, lat);
        chk("st1_latency", 64'(lat), 64'd4);
        chk("st1_ack_rdata", 64'(rd), 64'd0);
        pb_read(16'h0010, bd); chk("st1_mem10", 64'(bd), 64'hAA);
        pb_read(16'h0011, bd); chk("st1_mem11", 64'(bd), 64'hBB);
        pb_read(16'h0012, bd); chk("st1_mem12", 64'(bd), 64'hCC);
        pb_read(16'h0013, bd); chk("st1_mem13", 64'(bd), 64'hDD);
        do_req(1'b0, 16'h0010, 32'h0, 4'b0000, rd, lat);
        chk("ld1_latency", 64'(lat), 64'd5);
        chk("ld1_rdata", 64'(rd), 64'hDDCCBBAA);

        // Partial mask
        pb_write(16'h0020, 8'h11);
        pb_write(16'h0021, 8'h22);
        pb_write(16'h0022, 8'h33);
        pb_write(16'h0023, 8'h44);
        do_req(1'b1, 16'h0020, 32'hA0B0C0D0, 4'b0101, rd, lat);
        chk("st2_latency", 64'(lat), 64'd4);
        pb_read(16'h0020, bd); chk("st2_mem20", 64'(bd), 64'hD0);
        pb_read(16'h0021, bd); chk("st2_mem21", 64'(bd), 64'h22);
        pb_read(16'h0022, bd); chk("st2_mem22", 64'(bd), 64'hB0);
        pb_read(16'h0023, bd); chk("st2_mem23", 64'(bd), 64'h44);
        do_req(1'b0, 16'h0020, 32'h0, 4'b1111, rd, lat);
        chk("ld2_rdata", 64'(rd), 64'h44B022D0);

        // Address wrap at the top of the BRAM
        do_req(1'b1, 16'hFFFE, 32'h04030201, 4'b1111, rd, lat);
        wrap_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        wrap_d = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 4; i++) begin
            pb_read(wrap_a[i], bd);
            chk($sformatf("wrap_mem%0d", i), 64'(bd), 64'(wrap_d[i]));
        end
        do_req(1'b0, 16'hFFFE, 32'h0, 4'b0000, rd, lat);
        chk("wrap_ld_rdata", 64'(rd), 64'h04030201);

        // Response back-pressure
        core.req_valid = 1'b1;
        core.req_write = 1'b0;
        core.req_addr  = 16'h0010;
        tick();
        core.req_valid = 1'b0;
        lat = 0;
        while (!core.rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("bp_latency", 64'(lat), 64'd5);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("bp_valid_c%0d", i), 64'(core.rsp_valid), 64'd1);
            chk($sformatf("bp_rdata_c%0d", i), 64'(core.rsp_rdata), 64'hDDCCBBAA);
            chk($sformatf("bp_req_ready_c%0d", i), 64'(core.req_ready), 64'd0);
            chk($sformatf("bp_mem_write_c%0d", i), 64'(mem_write), 64'd0);
        end
        core.rsp_ready = 1'b1;
        tick();
        core.rsp_ready = 1'b0;
        chk("bp_valid_dropped", 64'(core.rsp_valid), 64'd0);
        chk("bp_req_ready_after", 64'(core.req_ready), 64'd1);

        // Reset in the middle of a store
        pb_write(16'h0040, 8'h00);
        pb_write(16'h0041, 8'h00);
        pb_write(16'h0042, 8'h5A);
        pb_write(16'h0043, 8'hA5);
        core.req_valid = 1'b1;
        core.req_write = 1'b1;
        core.req_addr  = 16'h0040;
        core.req_wdata = 32'h87654321;
        core.req_mask  = 4'b1111;
        tick();
        core.req_valid = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b0;
        #1;
        chk("mrst_mem_write", 64'(mem_write), 64'd0);
        chk("mrst_mem_addr", 64'(mem_addr), 64'd0);
        chk("mrst_mem_data", 64'(mem_wdata), 64'd0);
        chk("mrst_rsp_valid", 64'(core.rsp_valid), 64'd0);
        chk("mrst_rsp_rdata", 64'(core.rsp_rdata), 64'd0);
        tick();
        tick();
        i_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("mrst_no_rsp_c%0d", i), 64'(core.rsp_valid), 64'd0);
        end
        chk("mrst_req_ready", 64'(core.req_ready), 64'd1);
        pb_read(16'h0040, bd); chk("mrst_mem40", 64'(bd), 64'h21);
        pb_read(16'h0041, bd); chk("mrst_mem41", 64'(bd), 64'h43);
        pb_read(16'h0042, bd); chk("mrst_mem42", 64'(bd), 64'h5A);
        pb_read(16'h0043, bd); chk("mrst_mem43", 64'(bd), 64'hA5);

        // Back-to-back store/load pairs
        for (int i = 0; i < 8; i++) begin
            logic [AW-1:0] a;
            logic [31:0]   d;
            a = 16'h0100 + AW'(4 * i);
            d = 32'(i) * 32'h01010101;
            do_req(1'b1, a, d, 4'b1111, rd, lat);
            chk($sformatf("b2b_st%0d_ack", i), 64'(rd), 64'd0);
            do_req(1'b0, a, 32'h0, 4'b0000, rd, lat);
            chk($sformatf("b2b_ld%0d_rdata", i), 64'(rd), 64'(d));
        end

        tick();
        chk("rsp_count", 64'(rsp_count), 64'd23);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
